// File: rtl/decim_ctrl.sv
// Decimation controller: ratio-period tick generator, settle discard,
// small output FIFO with sticky overflow and drain-before-idle.
module decim_ctrl #(
  parameter int DW       = 12,
  parameter int CW       = 9,
  parameter int DEPTH    = 4,
  parameter int SETTLE_N = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [CW-1:0] ratio,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE_N + 2);
  localparam logic [SW-1:0] SETTLE_L = SW'(SETTLE_N);
  localparam logic [AW:0]   FULL_L   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN,
    DRAIN
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] ratio_q;
  logic [SW-1:0] settle_q;
  logic          busy_q;
  logic          ovf_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;

  logic          tick;
  logic          push;
  logic          pop;
  logic          wr;
  logic          empty;
  logic          full;
  logic          drop;
  logic          last;
  logic [AW:0]   level;
  logic [SW-1:0] settle_d;

  assign level    = wptr_q - rptr_q;
  assign empty    = (level == '0);
  assign full     = (level == FULL_L);
  assign last     = (level == (AW+1)'(1));
  assign tick     = (cnt_q == ratio_q);
  assign pop      = !empty && out_ready;
  assign push     = (state_q == RUN) && enable && tick;
  assign wr       = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign settle_d = settle_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      ratio_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_q  <= SETTLE;
            ratio_q  <= ratio;
            cnt_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        SETTLE, RUN: begin
          // Losing enable wins over any tick in the same cycle.
          if (!enable) begin
            state_q <= DRAIN;
          end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (state_q == SETTLE) begin
              if (SETTLE_L == '0) begin
                state_q <= RUN;
              end else if (tick) begin
                settle_q <= settle_d;
                if (settle_d == SETTLE_L) state_q <= RUN;
              end
            end
          end
        end
        DRAIN: begin
          if (empty || (last && pop)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      ovf_q <= drop | (ovf_q & ~clr_ovf);
    end
  end

  // Storage needs no reset: the head is gated by the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && wr) mem_q[wptr_q[AW-1:0]] <= data_in;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_decim_ctrl.sv
// Bench for decim_ctrl: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_decim_ctrl;

  localparam int DW       = 12;
  localparam int CW       = 9;
  localparam int DEPTH    = 4;
  localparam int SETTLE_N = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] ratio = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow;
  logic          clr_ovf = 1'b0;
  logic          busy;

  int errs = 0;
  int checks = 0;

  decim_ctrl #(
    .DW(DW), .CW(CW), .DEPTH(DEPTH), .SETTLE_N(SETTLE_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ratio(ratio), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow),
    .clr_ovf(clr_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: time since start, tick index = t / period.
  bit            m_busy;
  bit            m_drain;
  int            m_t;
  int            m_per;
  logic [DW-1:0] m_q[$];
  bit            m_ovf;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit rn, input bit en,
                       input logic [CW-1:0] rat,
                       input logic [DW-1:0] din,
                       input bit rdy, input bit clr);
    bit tk, psh, pp, drp;
    if (!rn) begin
      m_busy = 0; m_drain = 0; m_t = 0; m_per = 1;
      m_q.delete(); m_ovf = 0;
      return;
    end
    pp = (m_q.size() > 0) && rdy;
    psh = 0;
    drp = 0;
    if (m_busy && !m_drain && en) begin
      tk  = (m_t % m_per) == (m_per - 1);
      psh = tk && ((m_t / m_per) >= SETTLE_N);
      m_t++;
    end
    if (pp) void'(m_q.pop_front());
    if (psh) begin
      if (m_q.size() < DEPTH) m_q.push_back(din);
      else drp = 1;
    end
    m_ovf = drp ? 1'b1 : (clr ? 1'b0 : m_ovf);
    if (!m_busy) begin
      if (en) begin
        m_busy = 1; m_drain = 0; m_t = 0;
        m_per = int'(rat) + 1;
      end
    end else if (m_drain) begin
      if (m_q.size() == 0) m_busy = 0;
    end else if (!en) begin
      m_drain = 1;
    end
  endtask

  task automatic step(input bit rn, input bit en,
                      input logic [CW-1:0] rat,
                      input logic [DW-1:0] din,
                      input bit rdy, input bit clr);
    logic [DW-1:0] hd;
    rst_n = rn; enable = en; ratio = rat;
    data_in = din; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    model(rn, en, rat, din, rdy, clr);
    #1;
    hd = (m_q.size() > 0) ? m_q[0] : '0;
    chk("m_valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("m_data", 32'(out_data), 32'(hd));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_busy", 32'(busy), 32'(m_busy));
  endtask

  typedef struct {
    bit            rn;
    bit            en;
    logic [CW-1:0] rat;
    bit            rdy;
    bit            clr;
    bit            ev;
    logic [DW-1:0] ed;
    bit            eo;
    bit            eb;
  } vec_t;

  vec_t tbl[17];

  task automatic fill_table();
    tbl[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0,  0, 0, 1};
    tbl[2]  = '{1, 1, 0, 0, 0, 0,  0, 0, 1};
    tbl[3]  = '{1, 1, 0, 0, 0, 0,  0, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 0, 1, 14, 0, 1};
    tbl[5]  = '{1, 1, 5, 0, 0, 1, 14, 0, 1};
    tbl[6]  = '{1, 1, 5, 0, 0, 1, 14, 0, 1};
    tbl[7]  = '{1, 1, 5, 0, 0, 1, 14, 0, 1};
    tbl[8]  = '{1, 1, 5, 0, 0, 1, 14, 1, 1};
    tbl[9]  = '{1, 1, 5, 0, 1, 1, 14, 1, 1};
    tbl[10] = '{1, 0, 0, 0, 1, 1, 14, 0, 1};
    tbl[11] = '{1, 1, 0, 1, 0, 1, 15, 0, 1};
    tbl[12] = '{1, 1, 0, 1, 0, 1, 16, 0, 1};
    tbl[13] = '{1, 1, 0, 0, 0, 1, 16, 0, 1};
    tbl[14] = '{1, 1, 0, 1, 0, 1, 17, 0, 1};
    tbl[15] = '{1, 1, 0, 1, 0, 0,  0, 0, 0};
    tbl[16] = '{1, 0, 0, 1, 0, 0,  0, 0, 0};
  endtask

  task automatic seq_period();
    int  rises[$];
    bit  prev;
    step(0, 0, 0, 0, 1, 0);
    prev = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1, 1, (rises.size() >= 2) ? 9'd7 : 9'd3,
           DW'(i), 1, 0);
      if (out_valid && !prev) rises.push_back(i);
      prev = out_valid;
    end
    if (rises.size() >= 4) begin
      chk("first_valid_edge", 32'(rises[0]), 32'd13);
      chk("period_r3", 32'(rises[1] - rises[0]), 32'd4);
      chk("period_after_change", 32'(rises[3] - rises[2]), 32'd4);
    end else begin
      chk("valid_rises", 32'(rises.size()), 32'd4);
    end
  endtask

  task automatic seq_full_pass();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) step(1, 1, 0, DW'(100 + i), 0, 0);
    chk("full_valid", 32'(out_valid), 32'd1);
    for (int i = 8; i <= 13; i++) begin
      step(1, 1, 0, DW'(100 + i), 1, 0);
      chk("pass_valid", 32'(out_valid), 32'd1);
      chk("pass_noovf", 32'(overflow), 32'd0);
      chk("pass_data", 32'(out_data), 32'(100 + i - 3));
    end
  endtask

  task automatic seq_reset_run();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, 1, 0, DW'(200 + i), 0, 0);
    chk("two_queued", 32'(out_valid), 32'd1);
    step(0, 1, 0, 12'd300, 1, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    step(1, 1, 0, 12'd301, 0, 0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, DW'(310 + i), 0, 0);
    chk("restart_data", 32'(out_data), 32'd312);
  endtask

  task automatic seq_drain3();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) step(1, 1, 0, DW'(400 + i), 0, 0);
    step(1, 0, 0, 12'd499, 1, 0);
    for (int i = 0; i < 2; i++) begin
      chk("drain_busy", 32'(busy), 32'd1);
      step(1, 1, 0, 12'd498, 1, 0);
    end
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit            en_r;
    logic [CW-1:0] rat_r;
    bit            rdy_r;
    fill_table();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rn, tbl[i].en, tbl[i].rat,
           DW'(10 + i), tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
    end
    seq_period();
    seq_full_pass();
    seq_reset_run();
    seq_drain3();
    step(0, 0, 0, 0, 0, 0);
    en_r = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = !en_r;
      rat_r = ($urandom_range(0, 9) == 0) ? 9'd511
                                          : CW'($urandom_range(0, 4));
      if ((i / 150) % 2 == 1) rdy_r = ($urandom_range(0, 3) == 0);
      else rdy_r = ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 299) != 0, en_r, rat_r,
           DW'($urandom), rdy_r, $urandom_range(0, 15) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/decim_ctrl.md
DECIM_CTRL -- requirements
Module: decim_ctrl

Interface
REQ-001 Parameter: DW, 12, width of decimated sample data.
REQ-002 Parameter: CW, 9, width of decimation-period counter and ratio input.
REQ-003 Parameter: DEPTH, 4, output FIFO depth in entries (power of two, >=2).
REQ-004 Parameter: SETTLE_N, 2, number of decimated samples discarded after start.
REQ-005 Port: clk  input  1  clock; all logic on rising edge.
REQ-006 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port: enable  input  1  level; high requests conversion, low requests stop.
REQ-008 Port: ratio  input  CW  decimation period minus one; sampled only when leaving IDLE.
REQ-009 Port: data_in  input  DW  filtered sample stream from the decimation datapath.
REQ-010 Port: out_data  output  DW  FIFO head sample.
REQ-011 Port: out_valid  output  1  FIFO non-empty.
REQ-012 Port: out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-013 Port: overflow  output  1  sticky; a decimated sample was dropped.
REQ-014 Port: clr_ovf  input  1  single-cycle pulse clearing overflow.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, RUN, DRAIN.
REQ-017 IDLE -> SETTLE when enable=1: latch ratio into ratio_q, set period counter to 0, set settle count to 0.
REQ-018 In SETTLE and RUN, the counter SHALL increment each cycle; a tick SHALL occur when counter==ratio_q, and the counter SHALL return to 0 on that cycle (period = ratio_q+1 cycles).
REQ-019 ratio_q=0 SHALL tick every cycle; ratio_q=2^CW-1 SHALL tick every 2^CW cycles with no counter overflow.
REQ-020 SETTLE: each tick SHALL discard data_in and increment the settle count; the tick that brings the count to SETTLE_N SHALL move the FSM to RUN (SETTLE_N=0 means go to RUN on the first cycle).
REQ-021 RUN: each tick SHALL push data_in into the FIFO; out_valid SHALL rise the cycle after a push into an empty FIFO.
REQ-022 SETTLE or RUN with enable=0 -> DRAIN; a tick in that same cycle SHALL be ignored.
REQ-023 DRAIN: no pushes; -> IDLE on the cycle the FIFO becomes empty; enable=1 in DRAIN SHALL be ignored until IDLE is reached.
REQ-024 FIFO pop SHALL occur when out_valid && out_ready; out_data SHALL be stable while out_valid && !out_ready.
REQ-025 A push to a full FIFO with a pop in the same cycle SHALL succeed (occupancy unchanged).
REQ-026 A push to a full FIFO without a pop SHALL drop the sample, leave FIFO contents unchanged and set overflow the next cycle.
REQ-027 overflow SHALL clear on clr_ovf; if a drop and clr_ovf coincide, overflow SHALL be set.
REQ-028 FIFO read/write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-029 A change of ratio outside the IDLE->SETTLE transition SHALL have no effect.

Reset
REQ-030 With rst_n=0 at a clock edge: state=IDLE, counter=0, settle count=0, ratio_q=0, FIFO empty, out_valid=0, out_data=0, overflow=0, busy=0.
REQ-031 Reset mid-operation SHALL discard all FIFO contents and any in-progress period without producing a pop.
REQ-032 Reset SHALL override enable, clr_ovf and out_ready in the same cycle.

Verification
REQ-033 ratio=3, SETTLE_N=2, enable held, out_ready=1, data_in=cycle index -> first two ticks discarded; first out_valid one cycle after the 3rd tick, then every 4 cycles.
REQ-034 ratio=0, out_ready=0, DEPTH=4 -> 4 samples accepted after settle, 5th tick drops, overflow=1; clr_ovf pulse -> overflow=0 unless a drop occurs in the same cycle.
REQ-035 FIFO full, out_ready=1 at a tick -> no overflow, out_valid stays 1, samples emerge in order without a gap.
REQ-036 Deassert enable with 3 entries queued, out_ready=1 -> busy stays high 3 more pops, IDLE on the cycle the FIFO empties, no new pushes.
REQ-037 rst_n=0 for one cycle in RUN with 2 entries queued -> next cycle out_valid=0, busy=0, overflow=0; enable=1 restarts from SETTLE.
REQ-038 ratio changed from 3 to 7 during RUN -> period stays 4 cycles until the next IDLE->SETTLE transition.
